// File: rtl/q16_8_to_bcd_if.sv
// q16_8_to_bcd_if -- request/result bundle between the exponent stage,
// the BCD formatter and the display driver.
//   i_ce        clock enable (holds all formatter state when low)
//   i_start     start request, sampled only while the formatter is idle
//   i_val       unsigned Q16.8 value
//   i_err       upstream error flag, captured with i_val
//   o_int_bcd   integer digits, MS digit in the top nibble
//   o_frac_bcd  fraction digits, tenths in the top nibble
//   o_busy      formatter not idle
//   o_done      one-cycle completion pulse (stretched across i_ce stalls)
//   o_error     captured error flag
interface q16_8_to_bcd_if #(
  parameter int I_BITS      = 16,
  parameter int F_BITS      = 8,
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_DIGITS = 3
);
  logic                       i_ce;
  logic                       i_start;
  logic [I_BITS+F_BITS-1:0]   i_val;
  logic                       i_err;
  logic [INT_DIGITS*4-1:0]    o_int_bcd;
  logic [FRAC_DIGITS*4-1:0]   o_frac_bcd;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_error;

  modport master (
    output i_ce, i_start, i_val, i_err,
    input  o_int_bcd, o_frac_bcd, o_busy, o_done, o_error
  );

  modport slave (
    input  i_ce, i_start, i_val, i_err,
    output o_int_bcd, o_frac_bcd, o_busy, o_done, o_error
  );
endinterface

// File: rtl/q16_8_to_bcd.sv
// q16_8_to_bcd -- sequential Q16.8 to BCD formatter.
// The integer part runs through a 16-step double-dabble loop into 5 digits;
// the fraction is first scaled to thousandths ((f*1000)>>8, truncated) and
// then runs a 10-step double-dabble loop into 3 digits. One bit per enabled
// cycle, 26 enabled cycles from capture to o_done. An upstream error skips
// the conversion and reports zero digits with o_error set.
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-low reset, overrides i_ce
//   bus   slave side of q16_8_to_bcd_if (handshake, value, digits, status)
module q16_8_to_bcd #(
  parameter int I_BITS      = 16,
  parameter int F_BITS      = 8,
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_DIGITS = 3
) (
  input  logic CLK,
  input  logic RST,
  q16_8_to_bcd_if.slave bus
);

  localparam int IW = INT_DIGITS * 4;
  localparam int FW = FRAC_DIGITS * 4;
  // f*1000 < f*1024, so after dropping F_BITS the scaled fraction fits 10 bits
  localparam int SW = 10;
  localparam int PW = F_BITS + SW;
  localparam logic [4:0] INT_LAST  = 5'(I_BITS - 1);
  localparam logic [4:0] FRAC_LAST = 5'(SW - 1);

  typedef enum logic [1:0] {IDLE, INT_DD, FRAC_DD, DONE} state_t;

  state_t              state;
  logic [I_BITS-1:0]   int_bin;
  logic [F_BITS-1:0]   frac_raw;
  logic [SW-1:0]       frac_bin;
  logic [IW-1:0]       int_acc;
  logic [FW-1:0]       frac_acc;
  logic [4:0]          cnt;
  logic [IW-1:0]       int_bcd;
  logic [FW-1:0]       frac_bcd;
  logic                done;
  logic                error;

  // One double-dabble step: +3 on every nibble >= 5, then shift in a bit.
  function automatic logic [IW-1:0] dd_int(input logic [IW-1:0] acc,
                                           input logic bit_in);
    logic [IW-1:0] r;
    r = acc;
    for (int i = 0; i < INT_DIGITS; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return {r[IW-2:0], bit_in};
  endfunction

  function automatic logic [FW-1:0] dd_frac(input logic [FW-1:0] acc,
                                            input logic bit_in);
    logic [FW-1:0] r;
    r = acc;
    for (int i = 0; i < FRAC_DIGITS; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return {r[FW-2:0], bit_in};
  endfunction

  // f*1000 = f*1024 - f*16 - f*8, done with shifts; keep the top 10 bits.
  function automatic logic [SW-1:0] scale_frac(input logic [F_BITS-1:0] f);
    logic [PW-1:0] fe;
    logic [PW-1:0] p;
    fe = PW'(f);
    p  = (fe << 10) - (fe << 4) - (fe << 3);
    return p[PW-1:F_BITS];
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      int_bin  <= '0;
      frac_raw <= '0;
      frac_bin <= '0;
      int_acc  <= '0;
      frac_acc <= '0;
      cnt      <= '0;
      int_bcd  <= '0;
      frac_bcd <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else if (bus.i_ce) begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            int_bin  <= bus.i_val[I_BITS+F_BITS-1:F_BITS];
            frac_raw <= bus.i_val[F_BITS-1:0];
            if (bus.i_err) begin
              // error result is published on the capture edge itself
              int_bcd  <= '0;
              frac_bcd <= '0;
              done     <= 1'b1;
              error    <= 1'b1;
              state    <= DONE;
            end else begin
              int_acc  <= '0;
              frac_acc <= '0;
              cnt      <= '0;
              state    <= INT_DD;
            end
          end
        end
        INT_DD: begin
          int_acc <= dd_int(int_acc, int_bin[I_BITS-1]);
          int_bin <= int_bin << 1;
          if (cnt == INT_LAST) begin
            cnt      <= '0;
            frac_bin <= scale_frac(frac_raw);
            state    <= FRAC_DD;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FRAC_DD: begin
          frac_acc <= dd_frac(frac_acc, frac_bin[SW-1]);
          frac_bin <= frac_bin << 1;
          if (cnt == FRAC_LAST) begin
            // final step result goes straight to the output register
            cnt      <= '0;
            int_bcd  <= int_acc;
            frac_bcd <= dd_frac(frac_acc, frac_bin[SW-1]);
            done     <= 1'b1;
            error    <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_int_bcd  = int_bcd;
  assign bus.o_frac_bcd = frac_bcd;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_done     = done;
  assign bus.o_error    = error;

endmodule

// File: tb/tb_q16_8_to_bcd.sv
// tb_q16_8_to_bcd -- directed self-checking bench for q16_8_to_bcd.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_q16_8_to_bcd;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  q16_8_to_bcd_if bus ();

  q16_8_to_bcd dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start on the next edge (edge 0), then drop i_start.
  task automatic do_start(input logic [23:0] val, input logic err);
    bus.i_start = 1'b1;
    bus.i_val   = val;
    bus.i_err   = err;
    tick();
    bus.i_start = 1'b0;
    bus.i_err   = 1'b0;
    bus.i_val   = 24'hA5A5A5;  // later changes must not matter
  endtask

  // Edges after edge 0 until o_done is seen; -1 if it never shows up.
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (bus.o_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_ce = 1'b1; bus.i_start = 1'b0; bus.i_val = '0; bus.i_err = 1'b0;
    tick(); tick();
    checks++; if (bus.o_int_bcd !== 20'h0) begin errors++; $display("FAIL reset_int: got %h want 00000", bus.o_int_bcd); end
    checks++; if (bus.o_frac_bcd !== 12'h0) begin errors++; $display("FAIL reset_frac: got %h want 000", bus.o_frac_bcd); end
    checks++; if ({bus.o_busy, bus.o_done, bus.o_error} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/err got %b want 000", {bus.o_busy, bus.o_done, bus.o_error}); end
    // start asserted together with reset: nothing captured
    bus.i_start = 1'b1; bus.i_val = 24'h000100;
    tick();
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start: busy got %b want 0", bus.o_busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_one();
    int n;
    do_start(24'h000100, 1'b0);
    tick();  // edge 1
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL one_busy: got %b want 1", bus.o_busy); end
    wait_done(40, n);
    n = n + 1;  // account for the extra tick above
    checks++; if (n !== 26) begin errors++; $display("FAIL one_latency: got %0d want 26", n); end
    checks++; if (bus.o_int_bcd !== 20'h00001) begin errors++; $display("FAIL one_int: got %h want 00001", bus.o_int_bcd); end
    checks++; if (bus.o_frac_bcd !== 12'h000) begin errors++; $display("FAIL one_frac: got %h want 000", bus.o_frac_bcd); end
    checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL one_error: got %b want 0", bus.o_error); end
    tick();  // edge 27
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL one_done_width: got %b want 0", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL one_idle: busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_values();
    logic [23:0] vals [3];
    logic [19:0] ints [3];
    logic [11:0] fracs[3];
    int n;
    vals[0] = 24'h0002B8; ints[0] = 20'h00002; fracs[0] = 12'h718;
    vals[1] = 24'hFFFFFF; ints[1] = 20'h65535; fracs[1] = 12'h996;
    vals[2] = 24'h000000; ints[2] = 20'h00000; fracs[2] = 12'h000;
    for (int k = 0; k < 3; k++) begin
      do_start(vals[k], 1'b0);
      wait_done(40, n);
      checks++; if (n !== 26) begin errors++; $display("FAIL val%0d_latency: got %0d want 26", k, n); end
      checks++; if (bus.o_int_bcd !== ints[k]) begin errors++; $display("FAIL val%0d_int: got %h want %h", k, bus.o_int_bcd, ints[k]); end
      checks++; if (bus.o_frac_bcd !== fracs[k]) begin errors++; $display("FAIL val%0d_frac: got %h want %h", k, bus.o_frac_bcd, fracs[k]); end
      tick();  // edge 27, back to IDLE; next start lands on edge 28
    end
  endtask

  task automatic test_error();
    int n;
    do_start(24'h123456, 1'b1);  // edge 0
    checks++; if ({bus.o_done, bus.o_error} !== 2'b11) begin errors++; $display("FAIL err_flags: done/err got %b want 11", {bus.o_done, bus.o_error}); end
    checks++; if ({bus.o_int_bcd, bus.o_frac_bcd} !== 32'h0) begin errors++; $display("FAIL err_digits: got %h want 0", {bus.o_int_bcd, bus.o_frac_bcd}); end
    tick();  // edge 1
    checks++; if ({bus.o_done, bus.o_busy} !== 2'b00) begin errors++; $display("FAIL err_end: done/busy got %b want 00", {bus.o_done, bus.o_busy}); end
    checks++; if (bus.o_error !== 1'b1) begin errors++; $display("FAIL err_hold: error got %b want 1", bus.o_error); end
    do_start(24'h000100, 1'b0);  // edge 2
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL err_reaccept: busy got %b want 1", bus.o_busy); end
    wait_done(40, n);
    checks++; if (n !== 26 || bus.o_error !== 1'b0 || bus.o_int_bcd !== 20'h00001) begin errors++; $display("FAIL err_next: lat %0d err %b int %h want 26 0 00001", n, bus.o_error, bus.o_int_bcd); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int first;
    int pulses;
    int busy_bad;
    first = -1; pulses = 0; busy_bad = 0;
    do_start(24'h000A80, 1'b0);  // edge 0
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin bus.i_start = 1'b1; bus.i_val = 24'h000100; end
      tick();
      if (i == 5) bus.i_start = 1'b0;
      if (i <= 26 && bus.o_busy !== 1'b1) busy_bad++;
      if (bus.o_done === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 26) begin
        checks++; if (bus.o_int_bcd !== 20'h00010 || bus.o_frac_bcd !== 12'h500) begin errors++; $display("FAIL busy_digits: got %h/%h want 00010/500", bus.o_int_bcd, bus.o_frac_bcd); end
      end
    end
    checks++; if (first !== 26) begin errors++; $display("FAIL busy_latency: got %0d want 26", first); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_level: %0d low cycles want 0", busy_bad); end
  endtask

  task automatic test_stall();
    int n;
    do_start(24'h0002B8, 1'b0);
    for (int i = 1; i <= 5; i++) tick();
    bus.i_ce = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.i_ce = 1'b1;
    wait_done(40, n);
    n = n + 12;
    checks++; if (n !== 33) begin errors++; $display("FAIL stall_latency: got %0d want 33", n); end
    checks++; if (bus.o_int_bcd !== 20'h00002 || bus.o_frac_bcd !== 12'h718) begin errors++; $display("FAIL stall_digits: got %h/%h want 00002/718", bus.o_int_bcd, bus.o_frac_bcd); end
    bus.i_ce = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.o_done !== 1'b1) begin errors++; $display("FAIL stall_done_hold: got %b want 1", bus.o_done); end
    bus.i_ce = 1'b1;
    tick();
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL stall_done_fall: got %b want 0", bus.o_done); end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    pulses = 0;
    do_start(24'h000A80, 1'b0);
    for (int i = 1; i < 12; i++) tick();
    rst = 1'b0;
    tick();  // edge 12 under reset
    rst = 1'b1;
    checks++; if ({bus.o_int_bcd, bus.o_frac_bcd} !== 32'h0) begin errors++; $display("FAIL rmid_digits: got %h want 0", {bus.o_int_bcd, bus.o_frac_bcd}); end
    checks++; if ({bus.o_busy, bus.o_done, bus.o_error} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_error}); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
    do_start(24'h000100, 1'b0);
    wait_done(40, n);
    checks++; if (n !== 26 || bus.o_int_bcd !== 20'h00001 || bus.o_frac_bcd !== 12'h000) begin errors++; $display("FAIL rmid_restart: lat %0d got %h/%h want 26 00001/000", n, bus.o_int_bcd, bus.o_frac_bcd); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one();
    test_values();
    test_error();
    test_busy_ignore();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
